// File: rtl/fps_to_int_seq.sv
`timescale 1ns/1ps
// Iterative IEEE-754 single to signed 32-bit integer converter with a STEP-bit-per-cycle shifter.
// Define ROUND_NEAREST_EN for round-half-to-even; otherwise results truncate toward zero.
module fps_to_int_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        inv
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIX   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);
`ifdef ROUND_NEAREST_EN
  localparam logic [7:0] EXP_MIN = 8'd126;
`else
  localparam logic [7:0] EXP_MIN = 8'd127;
`endif

  state_t      r_state, w_next;
  logic [31:0] r_mag, r_result, w_mag_rnd, w_sp_result;
  logic [4:0]  r_rem, w_amt;
  logic        r_left, r_sign, r_ovf, r_inv;
  logic        w_accept, w_special, w_sp_ovf, w_sp_inv;
  logic [7:0]  w_exp, w_lrem, w_rrem;
  logic [22:0] w_frac;
`ifdef ROUND_NEAREST_EN
  logic        r_guard, r_sticky;
  logic [31:0] w_lowmask;
`endif

  assign w_exp     = a[30:23];
  assign w_frac    = a[22:0];
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign inv       = r_inv;
  assign w_lrem    = w_exp - 8'd150;
  assign w_rrem    = 8'd150 - w_exp;
  assign w_amt     = (r_rem > STEP_W) ? STEP_W : r_rem;

`ifdef ROUND_NEAREST_EN
  assign w_lowmask = (32'd1 << (w_amt - 5'd1)) - 32'd1;
  assign w_mag_rnd = r_mag + {31'b0, r_guard & (r_sticky | r_mag[0])};
`else
  assign w_mag_rnd = r_mag;
`endif

  // Operands that resolve without shifting go straight to DONE.
  always_comb begin
    w_special   = 1'b1;
    w_sp_result = '0;
    w_sp_ovf    = 1'b0;
    w_sp_inv    = 1'b0;
    if (w_exp == 8'hFF) begin
      if (w_frac != '0) begin
        w_sp_result = 32'h8000_0000;
        w_sp_inv    = 1'b1;
      end else begin
        w_sp_result = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_sp_ovf    = 1'b1;
      end
    end else if (w_exp < EXP_MIN) begin
      w_sp_result = '0;
    end else if (w_exp >= 8'd158) begin
      if (a == 32'hCF00_0000) begin
        w_sp_result = 32'h8000_0000;
      end else begin
        w_sp_result = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_sp_ovf    = 1'b1;
      end
    end else begin
      w_special = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_SHIFT;
      S_SHIFT: if (r_rem == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag    <= '0;
      r_rem    <= '0;
      r_left   <= 1'b0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_inv    <= 1'b0;
`ifdef ROUND_NEAREST_EN
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_sign <= a[31];
          if (w_special) begin
            r_result <= w_sp_result;
            r_ovf    <= w_sp_ovf;
            r_inv    <= w_sp_inv;
          end else begin
            r_mag  <= {8'b0, 1'b1, w_frac};
            r_left <= (w_exp >= 8'd150);
            r_rem  <= (w_exp >= 8'd150) ? w_lrem[4:0] : w_rrem[4:0];
`ifdef ROUND_NEAREST_EN
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
`endif
          end
        end
        S_SHIFT: if (r_rem != '0) begin
          r_rem <= r_rem - w_amt;
          if (r_left) begin
            r_mag <= r_mag << w_amt;
          end else begin
            r_mag <= r_mag >> w_amt;
`ifdef ROUND_NEAREST_EN
            r_guard  <= r_mag[w_amt - 5'd1];
            r_sticky <= r_sticky | r_guard | (|(r_mag & w_lowmask));
`endif
          end
        end
        S_FIX: r_result <= r_sign ? -w_mag_rnd : w_mag_rnd;
        S_DONE: if (out_ready) begin
          r_result <= '0;
          r_ovf    <= 1'b0;
          r_inv    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fps_to_int_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for fps_to_int_seq (STEP=1): directed operands, queued expectations, decoupled monitor.
module tb_fps_to_int_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, ovf, inv;
  logic [31:0] a, result;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        inv;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hs     = 0;
  int   n_ops    = 0;

`ifdef ROUND_NEAREST_EN
  localparam logic [31:0] E_M575 = 32'hFFFF_FFFA;
  localparam logic [31:0] E_15   = 32'd2;
  localparam logic [31:0] E_075  = 32'd1;
`else
  localparam logic [31:0] E_M575 = 32'hFFFF_FFFB;
  localparam logic [31:0] E_15   = 32'd1;
  localparam logic [31:0] E_075  = 32'd0;
`endif

  fps_to_int_seq #(.STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf), .inv(inv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per handshake cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_hs++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected no output", result);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
        chk("inv", {31'b0, inv}, {31'b0, e.inv});
      end
    end
  end

  // elat counts clock edges from the accept edge to out_valid; special operands show
  // out_valid in the cycle right after the accept cycle, i.e. 0 edges later. -1 skips.
  task automatic do_op(input logic [31:0] op, input logic [31:0] er, input logic eo,
                       input logic ei, input int elat, input int stall);
    exp_t e;
    int   lat;
    bit   got;
    e.res = er; e.ovf = eo; e.inv = ei;
    q.push_back(e);
    n_ops++;
    out_ready = (stall == 0);
    lat = 0;
    while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    a = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      if (out_valid) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    chk("out_valid_seen", {31'b0, got}, 32'd1);
    if (got && elat >= 0) chk("latency", 32'(lat), 32'(elat));
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_result", result, er);
      chk("stall_flags", {30'b0, ovf, inv}, {30'b0, eo, ei});
      a = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", {31'b0, out_valid}, 32'd0);
    chk("flags_clear", {30'b0, ovf, inv}, 32'd0);
    chk("handshakes", 32'(n_hs), 32'(n_ops));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'b0, ovf, inv}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    do_op(32'h3F80_0000, 32'd1,          0, 0, 25, 0);
    do_op(32'hC0B8_0000, E_M575,         0, 0, 23, 0);
    do_op(32'h3F00_0000, 32'd0,          0, 0, -1, 0);
    do_op(32'h3FC0_0000, E_15,           0, 0, 25, 0);
    do_op(32'h3F40_0000, E_075,          0, 0, -1, 0);
    do_op(32'h4020_0000, 32'd2,          0, 0, 24, 0);
    do_op(32'h42C8_0000, 32'd100,        0, 0, 19, 0);
    do_op(32'h4B00_0000, 32'h0080_0000,  0, 0,  2, 0);
    do_op(32'h4E80_0000, 32'h4000_0000,  0, 0,  9, 0);
    do_op(32'hCE80_0000, 32'hC000_0000,  0, 0,  9, 0);
    do_op(32'h4EFF_FFFF, 32'h7FFF_FF80,  0, 0,  9, 0);
    do_op(32'h4F00_0000, 32'h7FFF_FFFF,  1, 0,  0, 0);
    do_op(32'hCF00_0000, 32'h8000_0000,  0, 0,  0, 0);
    do_op(32'hCF00_0001, 32'h8000_0000,  1, 0,  0, 0);
    do_op(32'h7FC0_0000, 32'h8000_0000,  0, 1,  0, 0);
    do_op(32'hFF80_0000, 32'h8000_0000,  1, 0,  0, 0);
    do_op(32'h7F80_0000, 32'h7FFF_FFFF,  1, 0,  0, 0);
    do_op(32'h0000_0000, 32'd0,          0, 0,  0, 0);
    do_op(32'h8000_0001, 32'd0,          0, 0,  0, 0);
    do_op(32'hBF00_0000, 32'd0,          0, 0, -1, 0);
    do_op(32'hC0B8_0000, E_M575,         0, 0, 23, 5);

    // Abort a long conversion mid-shift; nothing may come out.
    a = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready_low_rst", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", {31'b0, seen}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);

    do_op(32'h3FC0_0000, E_15, 0, 0, 25, 0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
